// File: rtl/lp_conflict_monitor.sv
// Per-core LP/timestamp tracker: stalls same-LP conflicts, releases the oldest waiter on
// receive, keeps per-LP history and exports a registered minimum active timestamp.
module lp_conflict_monitor #(
   parameter int NUM_CORE = 8,
   parameter int NUM_LP   = 64,
   parameter int TIME_WID = 16,
   parameter int MSG_WID  = 32,
   parameter int HIST_WID = 4,
   parameter int CNT_WID  = 16,
   localparam int NB_CORE = $clog2(NUM_CORE),
   localparam int NB_LP   = $clog2(NUM_LP)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         send_vld,
   input  logic [NB_CORE-1:0]           send_core,
   input  logic [MSG_WID-1:0]           send_msg,
   input  logic                         rcv_vld,
   input  logic [NB_CORE-1:0]           rcv_core,
   input  logic [MSG_WID-1:0]           rcv_msg,
   output logic [NUM_CORE-1:0]          stall,
   output logic [NUM_CORE-1:0]          core_active,
   output logic [HIST_WID*NUM_CORE-1:0] core_hist_cnt,
   output logic [TIME_WID-1:0]          min_time,
   output logic                         min_time_vld,
   output logic [CNT_WID-1:0]           conflict_cnt,
   output logic                         err
);

   logic [TIME_WID-1:0] core_time_reg [NUM_CORE];
   logic [NB_LP-1:0]    core_lp_reg   [NUM_CORE];
   logic [HIST_WID-1:0] core_hist_reg [NUM_CORE];
   logic [HIST_WID-1:0] lp_hist_reg   [NUM_LP];
   logic [NUM_CORE-1:0] active_reg;
   logic [NUM_CORE-1:0] stall_reg;
   logic [TIME_WID-1:0] min_time_reg;
   logic                min_time_vld_reg;
   logic [CNT_WID-1:0]  conflict_cnt_reg;
   logic                err_reg;

   logic [TIME_WID-1:0] send_time;
   logic [NB_LP-1:0]    send_lp;
   logic [HIST_WID-1:0] rcv_hist;
   logic [NB_LP-1:0]    rcv_lp;
   logic [HIST_WID-1:0] send_hist;
   logic                rcv_ok;
   logic                proto_err;
   logic [NUM_CORE-1:0] send_match;
   logic [NUM_CORE-1:0] waiter;
   logic                unused_msg_bits;

   assign send_time = send_msg[TIME_WID-1:0];
   assign send_lp   = send_msg[TIME_WID +: NB_LP];
   assign rcv_hist  = rcv_msg[MSG_WID-1 -: HIST_WID];
   assign rcv_lp    = core_lp_reg[rcv_core];
   assign rcv_ok    = rcv_vld && active_reg[rcv_core];
   assign unused_msg_bits = ^{send_msg, rcv_msg};

   // A receive in the same cycle that writes this LP supplies the freshest history.
   assign send_hist = (rcv_vld && (rcv_lp == send_lp)) ? rcv_hist : lp_hist_reg[send_lp];

   assign proto_err = (rcv_vld && !active_reg[rcv_core])
                   || (send_vld && active_reg[send_core])
                   || (send_vld && rcv_vld && (send_core == rcv_core));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORE; gi++) begin : g_core
         assign send_match[gi] = active_reg[gi] && (core_lp_reg[gi] == send_lp)
                              && (NB_CORE'(gi) != send_core)
                              && !(rcv_vld && (NB_CORE'(gi) == rcv_core));
         assign waiter[gi] = active_reg[gi] && stall_reg[gi] && (core_lp_reg[gi] == rcv_lp)
                          && (NB_CORE'(gi) != rcv_core)
                          && !(send_vld && (NB_CORE'(gi) == send_core));
         assign core_hist_cnt[gi*HIST_WID +: HIST_WID] = core_hist_reg[gi];
      end
   endgenerate

   // Oldest waiter wins; strict compare keeps the lowest index on ties.
   logic                win_found;
   logic [NB_CORE-1:0]  win_idx;
   logic [TIME_WID-1:0] win_time;
   logic                min_found;
   logic [TIME_WID-1:0] min_next;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_time  = '0;
      min_found = 1'b0;
      min_next  = '0;
      for (int i = 0; i < NUM_CORE; i++) begin
         if (waiter[i] && (!win_found || (core_time_reg[i] < win_time))) begin
            win_found = 1'b1;
            win_idx   = NB_CORE'(i);
            win_time  = core_time_reg[i];
         end
         if (active_reg[i] && (!min_found || (core_time_reg[i] < min_next))) begin
            min_found = 1'b1;
            min_next  = core_time_reg[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CORE; i++) begin
            core_time_reg[i] <= '0;
            core_lp_reg[i]   <= '0;
            core_hist_reg[i] <= '0;
         end
         for (int i = 0; i < NUM_LP; i++) begin
            lp_hist_reg[i] <= '0;
         end
         active_reg       <= '0;
         stall_reg        <= '0;
         min_time_reg     <= '0;
         min_time_vld_reg <= 1'b0;
         conflict_cnt_reg <= '0;
         err_reg          <= 1'b0;
      end else begin
         if (rcv_vld) begin
            lp_hist_reg[rcv_lp]  <= rcv_hist;
            active_reg[rcv_core] <= 1'b0;
            stall_reg[rcv_core]  <= 1'b0;
            if (rcv_ok && win_found) begin
               stall_reg[win_idx]     <= 1'b0;
               core_hist_reg[win_idx] <= rcv_hist;
            end
         end
         // Send is written after receive so that a same-core send overrides it.
         if (send_vld) begin
            active_reg[send_core]    <= 1'b1;
            stall_reg[send_core]     <= |send_match;
            core_time_reg[send_core] <= send_time;
            core_lp_reg[send_core]   <= send_lp;
            core_hist_reg[send_core] <= send_hist;
            if ((|send_match) && (conflict_cnt_reg != {CNT_WID{1'b1}})) begin
               conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
            end
         end
         if (proto_err) begin
            err_reg <= 1'b1;
         end
         min_time_vld_reg <= |active_reg;
         if (min_found) begin
            min_time_reg <= min_next;
         end
      end
   end

   assign stall        = stall_reg;
   assign core_active  = active_reg;
   assign min_time     = min_time_reg;
   assign min_time_vld = min_time_vld_reg;
   assign conflict_cnt = conflict_cnt_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_lp_conflict_monitor.sv
// Scoreboard bench: stimulus pushes expected outputs from a rule-level model,
// a monitor pops and compares one entry after every clock edge.
module tb_lp_conflict_monitor;
   localparam int NUM_CORE = 8;
   localparam int NUM_LP   = 64;
   localparam int TIME_WID = 16;
   localparam int MSG_WID  = 32;
   localparam int HIST_WID = 4;
   localparam int CNT_WID  = 16;
   localparam int NB_CORE  = 3;
   localparam int CNT_MAX  = 65535;

   logic                         clk;
   logic                         reset;
   logic                         send_vld;
   logic [NB_CORE-1:0]           send_core;
   logic [MSG_WID-1:0]           send_msg;
   logic                         rcv_vld;
   logic [NB_CORE-1:0]           rcv_core;
   logic [MSG_WID-1:0]           rcv_msg;
   logic [NUM_CORE-1:0]          stall;
   logic [NUM_CORE-1:0]          core_active;
   logic [HIST_WID*NUM_CORE-1:0] core_hist_cnt;
   logic [TIME_WID-1:0]          min_time;
   logic                         min_time_vld;
   logic [CNT_WID-1:0]           conflict_cnt;
   logic                         err;

   lp_conflict_monitor #(
      .NUM_CORE(NUM_CORE), .NUM_LP(NUM_LP), .TIME_WID(TIME_WID),
      .MSG_WID(MSG_WID), .HIST_WID(HIST_WID), .CNT_WID(CNT_WID)
   ) dut (
      .clk(clk), .reset(reset),
      .send_vld(send_vld), .send_core(send_core), .send_msg(send_msg),
      .rcv_vld(rcv_vld), .rcv_core(rcv_core), .rcv_msg(rcv_msg),
      .stall(stall), .core_active(core_active), .core_hist_cnt(core_hist_cnt),
      .min_time(min_time), .min_time_vld(min_time_vld),
      .conflict_cnt(conflict_cnt), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  stall;
      logic [7:0]  act;
      logic [31:0] hist;
      logic [15:0] mt;
      logic        mv;
      logic [15:0] cnt;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   n_fail_print = 0;
   int   n_txn = 0;
   bit   verbose = 1;

   // Reference state: what each core is doing, in plain terms.
   bit m_act   [NUM_CORE];
   bit m_stall [NUM_CORE];
   int m_time  [NUM_CORE];
   int m_lp    [NUM_CORE];
   int m_hist  [NUM_CORE];
   int m_lph   [NUM_LP];
   int m_min;
   bit m_mv;
   int m_cnt;
   bit m_err;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         if (n_fail_print < 20) $display("FAIL %s: got %0h, expected %0h", name, act, req);
         n_fail_print++;
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CORE; c++) begin
         m_act[c] = 0; m_stall[c] = 0; m_time[c] = 0; m_lp[c] = 0; m_hist[c] = 0;
      end
      for (int l = 0; l < NUM_LP; l++) m_lph[l] = 0;
      m_min = 0; m_mv = 0; m_cnt = 0; m_err = 0;
   endtask

   task automatic model_apply(bit sv, int sc, int lp, int t, bit rv, int rc, int h);
      bit o_act[NUM_CORE];
      bit o_stall[NUM_CORE];
      int o_lp[NUM_CORE];
      int o_time[NUM_CORE];
      int waiters[$];
      int active_times[$];
      int others;
      for (int c = 0; c < NUM_CORE; c++) begin
         o_act[c] = m_act[c]; o_stall[c] = m_stall[c]; o_lp[c] = m_lp[c]; o_time[c] = m_time[c];
         if (o_act[c]) active_times.push_back(o_time[c]);
      end
      // GVT output reflects the table as it stood before this edge.
      m_mv = (active_times.size() > 0);
      if (m_mv) begin
         active_times.sort();
         m_min = active_times[0];
      end
      if (rv) begin
         int rlp = o_lp[rc];
         if (!o_act[rc]) m_err = 1;
         else begin
            for (int c = 0; c < NUM_CORE; c++)
               if (c != rc && !(sv && c == sc) && o_act[c] && o_stall[c] && o_lp[c] == rlp)
                  waiters.push_back(c);
            if (waiters.size() > 0) begin
               int best = waiters[0];
               foreach (waiters[k]) if (o_time[waiters[k]] < o_time[best]) best = waiters[k];
               m_stall[best] = 0;
               m_hist[best]  = h;
            end
         end
         m_act[rc] = 0; m_stall[rc] = 0;
         m_lph[rlp] = h;
      end
      if (sv) begin
         if (o_act[sc] || (rv && rc == sc)) m_err = 1;
         others = 0;
         for (int c = 0; c < NUM_CORE; c++)
            if (c != sc && !(rv && c == rc) && o_act[c] && o_lp[c] == lp) others++;
         m_act[sc] = 1; m_time[sc] = t; m_lp[sc] = lp; m_hist[sc] = m_lph[lp];
         m_stall[sc] = (others > 0);
         if (others > 0 && m_cnt < CNT_MAX) m_cnt++;
      end
   endtask

   function automatic exp_t model_snapshot();
      exp_t e;
      e.hist = '0;
      for (int c = 0; c < NUM_CORE; c++) begin
         e.stall[c] = m_stall[c];
         e.act[c]   = m_act[c];
         e.hist[c*4 +: 4] = 4'(m_hist[c]);
      end
      e.mt = 16'(m_min); e.mv = m_mv; e.cnt = 16'(m_cnt); e.err = m_err;
      return e;
   endfunction

   task automatic step(bit sv, int sc, int lp, int t, bit rv, int rc, int h);
      @(negedge clk);
      send_vld  = sv;
      send_core = 3'(sc);
      send_msg  = {10'($urandom), 6'(lp), 16'(t)};
      rcv_vld   = rv;
      rcv_core  = 3'(rc);
      rcv_msg   = {4'(h), 28'($urandom)};
      model_apply(sv, sc, lp, t, rv, rc, h);
      exp_q.push_back(model_snapshot());
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain_all();
      for (int c = 0; c < NUM_CORE; c++)
         if (m_act[c]) step(0, 0, 0, 0, 1, c, $urandom_range(0, 15));
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_stall"}, 64'(stall), 0);
      chk({tag, "_active"}, 64'(core_active), 0);
      chk({tag, "_hist"}, 64'(core_hist_cnt), 0);
      chk({tag, "_min"}, 64'(min_time), 0);
      chk({tag, "_minvld"}, 64'(min_time_vld), 0);
      chk({tag, "_cnt"}, 64'(conflict_cnt), 0);
      chk({tag, "_err"}, 64'(err), 0);
   endtask

   // Monitor: one scoreboard entry per clock edge while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            if (verbose)
               $display("txn %0d: stall=%02h act=%02h hist=%08h min=%0d/%0b cnt=%0d err=%0b",
                        n_txn, stall, core_active, core_hist_cnt, min_time, min_time_vld,
                        conflict_cnt, err);
            chk("stall", 64'(stall), 64'(e.stall));
            chk("core_active", 64'(core_active), 64'(e.act));
            chk("core_hist_cnt", 64'(core_hist_cnt), 64'(e.hist));
            chk("min_time", 64'(min_time), 64'(e.mt));
            chk("min_time_vld", 64'(min_time_vld), 64'(e.mv));
            chk("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
            chk("err", 64'(err), 64'(e.err));
         end
      end
   end

   initial begin
      reset = 1'b0;
      send_vld = 0; send_core = '0; send_msg = '0;
      rcv_vld = 0; rcv_core = '0; rcv_msg = '0;
      model_reset();
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Conflict and ordered release on LP5
      step(1, 0, 5, 10, 0, 0, 0);
      step(1, 1, 5, 20, 0, 0, 0);
      after_edge();
      chk("dir_conflict_stall", 64'(stall), 64'h02);
      chk("dir_conflict_cnt", 64'(conflict_cnt), 1);
      step(1, 2, 5, 15, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 3);
      after_edge();
      chk("dir_release_stall", 64'(stall), 64'h02);
      chk("dir_release_hist2", 64'(core_hist_cnt[8 +: 4]), 3);
      // Receive and send on the same LP in one cycle
      step(1, 3, 5, 7, 1, 2, 9);
      after_edge();
      chk("dir_simul_stall", 64'(stall), 64'h08);
      chk("dir_simul_hist3", 64'(core_hist_cnt[12 +: 4]), 9);
      idle(1);
      drain_all();
      idle(2);

      // Minimum timestamp
      step(1, 4, 1, 40, 0, 0, 0);
      step(1, 5, 2, 12, 0, 0, 0);
      step(1, 6, 3, 25, 0, 0, 0);
      idle(1);
      after_edge();
      chk("dir_min_time", 64'(min_time), 12);
      chk("dir_min_vld", 64'(min_time_vld), 1);
      drain_all();
      idle(2);
      after_edge();
      chk("dir_min_vld_off", 64'(min_time_vld), 0);

      // Protocol errors
      step(0, 0, 0, 0, 1, 7, 5);
      idle(1);
      after_edge();
      chk("dir_err_idle_rcv", 64'(err), 1);
      step(1, 3, 9, 100, 0, 0, 0);
      step(1, 3, 9, 50, 1, 3, 2);
      idle(1);
      drain_all();
      idle(1);

      // Randomized traffic over a small LP range to force conflicts
      for (int i = 0; i < 400; i++) begin
         bit sv = ($urandom_range(0, 3) != 0);
         bit rv = ($urandom_range(0, 2) != 0);
         int rc = $urandom_range(0, NUM_CORE - 1);
         if ($urandom_range(0, 4) != 0)
            for (int c = 0; c < NUM_CORE; c++) if (m_act[(rc + c) % NUM_CORE]) begin
               rc = (rc + c) % NUM_CORE;
               break;
            end
         step(sv, $urandom_range(0, NUM_CORE - 1), $urandom_range(0, 3),
              $urandom_range(0, 65535), rv, rc, $urandom_range(0, 15));
      end
      idle(2);

      // Saturate the conflict counter
      verbose = 0;
      step(1, 0, 5, 1, 0, 0, 0);
      for (int i = 0; i < CNT_MAX + 4; i++) step(1, 1, 5, i & 16'hFFFF, 0, 0, 0);
      after_edge();
      verbose = 1;
      chk("dir_cnt_sat", 64'(conflict_cnt), 64'hFFFF);
      chk("dir_err_sticky", 64'(err), 1);

      // Asynchronous reset with cores active, away from any clock edge
      #1;
      reset = 1'b0;
      send_vld = 0; rcv_vld = 0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle(3);
      step(1, 2, 7, 33, 0, 0, 0);
      idle(3);
      after_edge();
      chk("scoreboard_drained", 64'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
